// File: rtl/wbs_slave_ctrl.sv
// Wishbone classic slave that fronts the accelerator core.
// It provides the MODE/DEBUG/DONE/BUSY/FSM_START control registers, write
// ports into the node, leaf and query memories, and a read path from the
// result (BEST) memory.
module wbs_slave_ctrl #(
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
    parameter logic [31:0] BASE_CSR  = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,

    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,

    output logic        node_we,
    output logic [5:0]  node_addr,
    output logic [21:0] node_wdata,

    output logic        leaf_we,
    output logic [8:0]  leaf_addr,
    output logic [63:0] leaf_wdata,

    output logic        query_we,
    output logic [8:0]  query_addr,
    output logic [54:0] query_wdata,

    output logic        best_re,
    output logic [8:0]  best_addr,
    input  logic [63:0] best_rdata,

    output logic        fsm_start,
    input  logic        fsm_done,
    input  logic        fsm_busy,

    output logic        mode_o,
    output logic        debug_o
);

    localparam logic [31:0] REGION_QUERY = 32'h3001_0000;
    localparam logic [31:0] REGION_LEAF  = 32'h3002_0000;
    localparam logic [31:0] REGION_BEST  = 32'h3003_0000;
    localparam logic [31:0] REGION_NODE  = 32'h3004_0000;

    localparam logic [15:0] CSR_MODE  = 16'h0000;
    localparam logic [15:0] CSR_DEBUG = 16'h0004;
    localparam logic [15:0] CSR_DONE  = 16'h0008;
    localparam logic [15:0] CSR_START = 16'h000C;
    localparam logic [15:0] CSR_BUSY  = 16'h0010;

    // ST_BEST_WAIT covers the cycle in which the result memory returns data.
    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_BEST_WAIT = 1'b1
    } state_t;

    state_t      state_q,       state_d;
    logic        best_hi_q,     best_hi_d;
    logic        ack_q,         ack_d;
    logic [31:0] dat_q,         dat_d;
    logic        mode_q,        mode_d;
    logic        debug_q,       debug_d;
    logic        done_q,        done_d;
    logic        fsm_start_q,   fsm_start_d;
    logic [31:0] leaf_low_q,    leaf_low_d;
    logic [31:0] query_low_q,   query_low_d;
    logic        node_we_q,     node_we_d;
    logic [5:0]  node_addr_q,   node_addr_d;
    logic [21:0] node_wdata_q,  node_wdata_d;
    logic        leaf_we_q,     leaf_we_d;
    logic [8:0]  leaf_addr_q,   leaf_addr_d;
    logic [63:0] leaf_wdata_q,  leaf_wdata_d;
    logic        query_we_q,    query_we_d;
    logic [8:0]  query_addr_q,  query_addr_d;
    logic [54:0] query_wdata_q, query_wdata_d;

    logic [31:0] region;
    logic [15:0] offset;
    logic        hit_csr, hit_query, hit_leaf, hit_best, hit_node;
    logic        req_accept;
    logic        csr_wr, csr_rd, node_wr, leaf_wr, query_wr, best_rd;
    logic        done_clear;
    logic [31:0] csr_rdata;
    logic [63:0] leaf_word, query_word;
    logic        unused_sel;

    // Byte selects carry no meaning here: every access is a full word.
    assign unused_sel = ^wbs_sel_i;

    assign region = wbs_adr_i & ADDR_MASK;
    assign offset = wbs_adr_i[15:0];

    assign hit_csr   = (region == BASE_CSR);
    assign hit_query = (region == REGION_QUERY);
    assign hit_leaf  = (region == REGION_LEAF);
    assign hit_best  = (region == REGION_BEST);
    assign hit_node  = (region == REGION_NODE);

    // A new request is only taken while idle and not acknowledging the previous one.
    assign req_accept = wbs_cyc_i & wbs_stb_i & ~ack_q & (state_q == ST_IDLE);

    assign csr_wr   = req_accept &  wbs_we_i & hit_csr;
    assign csr_rd   = req_accept & ~wbs_we_i & hit_csr;
    assign node_wr  = req_accept &  wbs_we_i & hit_node;
    assign leaf_wr  = req_accept &  wbs_we_i & hit_leaf;
    assign query_wr = req_accept &  wbs_we_i & hit_query;
    assign best_rd  = req_accept & ~wbs_we_i & hit_best;

    // The result memory samples the read on the accepting edge, so the read
    // strobe is driven straight from the decode; reset forces it quiet.
    assign best_re   = rst_n & best_rd;
    assign best_addr = best_re ? offset[11:3] : 9'd0;

    // Control registers: MODE/DEBUG storage, start pulse and sticky done flag.
    always_comb begin
        mode_d      = mode_q;
        debug_d     = debug_q;
        fsm_start_d = 1'b0;
        done_clear  = fsm_start_q;
        if (csr_wr) begin
            case (offset)
                CSR_MODE:  mode_d      = wbs_dat_i[0];
                CSR_DEBUG: debug_d     = wbs_dat_i[0];
                CSR_DONE:  done_clear  = 1'b1;
                CSR_START: fsm_start_d = ~fsm_busy;
                default:   ;
            endcase
        end
        done_d = fsm_done | (done_q & ~done_clear);
    end

    // Memory write ports; leaf/query words are assembled from two bus beats.
    always_comb begin
        node_we_d     = 1'b0;
        node_addr_d   = 6'd0;
        node_wdata_d  = 22'd0;
        leaf_we_d     = 1'b0;
        leaf_addr_d   = 9'd0;
        leaf_wdata_d  = 64'd0;
        query_we_d    = 1'b0;
        query_addr_d  = 9'd0;
        query_wdata_d = 55'd0;
        leaf_low_d    = leaf_low_q;
        query_low_d   = query_low_q;
        leaf_word     = {wbs_dat_i, leaf_low_q};
        query_word    = {wbs_dat_i, query_low_q};

        if (node_wr) begin
            node_we_d    = 1'b1;
            node_addr_d  = offset[7:2];
            node_wdata_d = wbs_dat_i[21:0];
        end

        if (leaf_wr) begin
            if (offset[2]) begin
                leaf_we_d    = 1'b1;
                leaf_addr_d  = offset[11:3];
                leaf_wdata_d = leaf_word;
                leaf_low_d   = 32'd0;
            end else begin
                leaf_low_d   = wbs_dat_i;
            end
        end

        if (query_wr) begin
            if (offset[2]) begin
                query_we_d    = 1'b1;
                query_addr_d  = offset[11:3];
                query_wdata_d = query_word[54:0];
                query_low_d   = 32'd0;
            end else begin
                query_low_d   = wbs_dat_i;
            end
        end
    end

    // Bus response: single-cycle ack, read data only while ack is high.
    always_comb begin
        state_d   = state_q;
        best_hi_d = best_hi_q;
        ack_d     = 1'b0;
        dat_d     = 32'd0;
        csr_rdata = 32'd0;

        case (offset)
            CSR_MODE:  csr_rdata = {31'd0, mode_q};
            CSR_DEBUG: csr_rdata = {31'd0, debug_q};
            CSR_DONE:  csr_rdata = {31'd0, done_q};
            CSR_BUSY:  csr_rdata = {31'd0, fsm_busy};
            default:   csr_rdata = 32'd0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (req_accept) begin
                    if (best_rd) begin
                        state_d   = ST_BEST_WAIT;
                        best_hi_d = offset[2];
                    end else begin
                        ack_d = 1'b1;
                        if (csr_rd) begin
                            dat_d = csr_rdata;
                        end
                    end
                end
            end
            ST_BEST_WAIT: begin
                state_d = ST_IDLE;
                if (wbs_cyc_i & wbs_stb_i) begin
                    ack_d = 1'b1;
                    dat_d = best_hi_q ? best_rdata[63:32] : best_rdata[31:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All state and registered outputs, cleared immediately by reset.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            best_hi_q     <= 1'b0;
            ack_q         <= 1'b0;
            dat_q         <= 32'd0;
            mode_q        <= 1'b0;
            debug_q       <= 1'b0;
            done_q        <= 1'b0;
            fsm_start_q   <= 1'b0;
            leaf_low_q    <= 32'd0;
            query_low_q   <= 32'd0;
            node_we_q     <= 1'b0;
            node_addr_q   <= 6'd0;
            node_wdata_q  <= 22'd0;
            leaf_we_q     <= 1'b0;
            leaf_addr_q   <= 9'd0;
            leaf_wdata_q  <= 64'd0;
            query_we_q    <= 1'b0;
            query_addr_q  <= 9'd0;
            query_wdata_q <= 55'd0;
        end else begin
            state_q       <= state_d;
            best_hi_q     <= best_hi_d;
            ack_q         <= ack_d;
            dat_q         <= dat_d;
            mode_q        <= mode_d;
            debug_q       <= debug_d;
            done_q        <= done_d;
            fsm_start_q   <= fsm_start_d;
            leaf_low_q    <= leaf_low_d;
            query_low_q   <= query_low_d;
            node_we_q     <= node_we_d;
            node_addr_q   <= node_addr_d;
            node_wdata_q  <= node_wdata_d;
            leaf_we_q     <= leaf_we_d;
            leaf_addr_q   <= leaf_addr_d;
            leaf_wdata_q  <= leaf_wdata_d;
            query_we_q    <= query_we_d;
            query_addr_q  <= query_addr_d;
            query_wdata_q <= query_wdata_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign mode_o      = mode_q;
    assign debug_o     = debug_q;
    assign fsm_start   = fsm_start_q;
    assign node_we     = node_we_q;
    assign node_addr   = node_addr_q;
    assign node_wdata  = node_wdata_q;
    assign leaf_we     = leaf_we_q;
    assign leaf_addr   = leaf_addr_q;
    assign leaf_wdata  = leaf_wdata_q;
    assign query_we    = query_we_q;
    assign query_addr  = query_addr_q;
    assign query_wdata = query_wdata_q;

endmodule

// File: tb/tb_wbs_slave_ctrl.sv
// Testbench for wbs_slave_ctrl: directed scenarios followed by random bus
// traffic checked against a register/memory-level model of the slave.
module tb_wbs_slave_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        node_we, leaf_we, query_we, best_re, fsm_start, mode_o, debug_o;
    logic [5:0]  node_addr;
    logic [21:0] node_wdata;
    logic [8:0]  leaf_addr, query_addr, best_addr;
    logic [63:0] leaf_wdata;
    logic [54:0] query_wdata;
    logic [63:0] best_rdata = '0;
    logic        fsm_done = 1'b0, fsm_busy = 1'b0;

    int nAsserts = 0;
    int nFail = 0;

    logic [63:0] bestMem [0:511];

    int cycleNo = 0;
    int nodeCnt = 0, leafCnt = 0, queryCnt = 0, bestCnt = 0, startCnt = 0, ackCnt = 0;
    int overlapCnt = 0, leakCnt = 0, bestReCycle = -1;
    logic [5:0]  lastNodeAddr = '0;
    logic [21:0] lastNodeData = '0;
    logic [8:0]  lastLeafAddr = '0, lastQueryAddr = '0;
    logic [63:0] lastLeafData = '0;
    logic [54:0] lastQueryData = '0;

    wbs_slave_ctrl dut (
        .wb_clk_i    (clk),
        .rst_n       (rst_n),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .node_we     (node_we),
        .node_addr   (node_addr),
        .node_wdata  (node_wdata),
        .leaf_we     (leaf_we),
        .leaf_addr   (leaf_addr),
        .leaf_wdata  (leaf_wdata),
        .query_we    (query_we),
        .query_addr  (query_addr),
        .query_wdata (query_wdata),
        .best_re     (best_re),
        .best_addr   (best_addr),
        .best_rdata  (best_rdata),
        .fsm_start   (fsm_start),
        .fsm_done    (fsm_done),
        .fsm_busy    (fsm_busy),
        .mode_o      (mode_o),
        .debug_o     (debug_o)
    );

    always #5 clk = ~clk;

    // Result memory with one cycle of read latency.
    always @(posedge clk) begin
        cycleNo <= cycleNo + 1;
        if (best_re) best_rdata <= bestMem[best_addr];
    end

    // Passive monitor: counts strobe cycles and remembers the last write seen.
    always @(negedge clk) begin
        if (node_we)  begin nodeCnt  <= nodeCnt + 1;  lastNodeAddr  <= node_addr;  lastNodeData  <= node_wdata;  end
        if (leaf_we)  begin leafCnt  <= leafCnt + 1;  lastLeafAddr  <= leaf_addr;  lastLeafData  <= leaf_wdata;  end
        if (query_we) begin queryCnt <= queryCnt + 1; lastQueryAddr <= query_addr; lastQueryData <= query_wdata; end
        if (best_re)  begin bestCnt  <= bestCnt + 1;  bestReCycle   <= cycleNo; end
        if (fsm_start) startCnt <= startCnt + 1;
        if (wbs_ack_o) ackCnt <= ackCnt + 1;
        if ((int'(node_we) + int'(leaf_we) + int'(query_we) + int'(best_re)) > 1) overlapCnt <= overlapCnt + 1;
        if (!wbs_ack_o && (wbs_dat_o != 32'd0)) leakCnt <= leakCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One Wishbone classic transfer; lat is the number of edges until ack (0 = none).
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic pulseDone, output logic [31:0] rdata,
                                 output int lat, output int startCyc);
        int i;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        fsm_done  = pulseDone;
        startCyc  = cycleNo;
        lat       = 0;
        rdata     = '0;
        i         = 0;
        while (lat == 0 && i < 8) begin
            i++;
            @(posedge clk); #1;
            fsm_done = 1'b0;
            if (wbs_ack_o) begin
                lat   = i;
                rdata = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulseFsmDone();
        fsm_done = 1'b1;
        @(posedge clk); #1;
        fsm_done = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat, sc, c0, c1, c2, c3, c4, a0;
        logic        mMode, mDebug, mDone, busy, we, expNode, expLeaf, expQuery, expStart, expBest;
        logic [31:0] mLeafLow, mQueryLow, d, base, expRd;
        logic [15:0] off;
        logic [63:0] word, expLeafData, qword;
        logic [54:0] expQueryData;
        int          kind, expLat;

        for (int i = 0; i < 512; i++) bestMem[i] = {$urandom, $urandom};
        bestMem[5] = 64'hAAAA_5555_0000_07FF;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_ack",      64'(wbs_ack_o), 64'(0));
        checkOutput("rst_dat",      64'(wbs_dat_o), 64'(0));
        checkOutput("rst_strobes",  64'({node_we, leaf_we, query_we, best_re, fsm_start}), 64'(0));
        checkOutput("rst_mode_dbg", 64'({mode_o, debug_o}), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset released");

        // DEBUG write then read back
        applyStimulus(1'b1, 32'h3000_0004, 32'h1, 1'b0, rd, lat, sc);
        checkOutput("debug_wr_lat", 64'(lat), 64'(1));
        checkOutput("debug_o", 64'(debug_o), 64'(1));
        applyStimulus(1'b0, 32'h3000_0004, 32'h0, 1'b0, rd, lat, sc);
        checkOutput("debug_rd_lat", 64'(lat), 64'(1));
        checkOutput("debug_rd", 64'(rd), 64'(32'h1));

        // NODE write
        c0 = nodeCnt;
        applyStimulus(1'b1, 32'h3004_0008, {10'b0, 11'd55, 11'd1}, 1'b0, rd, lat, sc);
        checkOutput("node_lat",   64'(lat), 64'(1));
        checkOutput("node_count", 64'(nodeCnt - c0), 64'(1));
        checkOutput("node_addr",  64'(lastNodeAddr), 64'(2));
        checkOutput("node_data",  64'(lastNodeData), 64'(22'h1B801));

        // LEAF two-beat write
        c0 = leafCnt;
        applyStimulus(1'b1, 32'h3002_0018, 32'hDEAD_BEEF, 1'b0, rd, lat, sc);
        checkOutput("leaf_lo_count", 64'(leafCnt - c0), 64'(0));
        applyStimulus(1'b1, 32'h3002_001C, 32'h1234_5678, 1'b0, rd, lat, sc);
        checkOutput("leaf_hi_count", 64'(leafCnt - c0), 64'(1));
        checkOutput("leaf_addr", 64'(lastLeafAddr), 64'(3));
        checkOutput("leaf_data", lastLeafData, 64'h1234_5678_DEAD_BEEF);

        // BEST reads, both halves
        c0 = bestCnt;
        applyStimulus(1'b0, 32'h3003_0028, 32'h0, 1'b0, rd, lat, sc);
        checkOutput("best_lo_lat",   64'(lat), 64'(2));
        checkOutput("best_lo_data",  64'(rd), 64'(32'h0000_07FF));
        checkOutput("best_re_count", 64'(bestCnt - c0), 64'(1));
        checkOutput("best_re_at_T0", 64'(bestReCycle), 64'(sc));
        applyStimulus(1'b0, 32'h3003_002C, 32'h0, 1'b0, rd, lat, sc);
        checkOutput("best_hi_data",  64'(rd), 64'(32'hAAAA_5555));

        // Start while busy / idle, sticky done behaviour
        fsm_busy = 1'b1;
        c0 = startCnt;
        applyStimulus(1'b1, 32'h3000_000C, 32'h1, 1'b0, rd, lat, sc);
        checkOutput("start_busy_lat",   64'(lat), 64'(1));
        checkOutput("start_busy_pulse", 64'(startCnt - c0), 64'(0));
        fsm_busy = 1'b0;
        applyStimulus(1'b1, 32'h3000_000C, 32'h1, 1'b0, rd, lat, sc);
        checkOutput("start_idle_pulse", 64'(startCnt - c0), 64'(1));
        pulseFsmDone();
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 1'b0, rd, lat, sc);
        checkOutput("done_set", 64'(rd), 64'(1));
        applyStimulus(1'b1, 32'h3000_0008, 32'h0, 1'b0, rd, lat, sc);
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 1'b0, rd, lat, sc);
        checkOutput("done_cleared", 64'(rd), 64'(0));
        applyStimulus(1'b1, 32'h3000_0008, 32'h0, 1'b1, rd, lat, sc);
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 1'b0, rd, lat, sc);
        checkOutput("done_set_wins", 64'(rd), 64'(1));

        // Master abandons a BEST read before the ack
        a0 = ackCnt;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3003_0010;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_no_ack", 64'(ackCnt - a0), 64'(0));

        // Random traffic against the model
        mMode = 1'b0; mDebug = 1'b1; mDone = 1'b1; mLeafLow = '0; mQueryLow = '0;
        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 5));
            we   = 1'($urandom_range(0, 1));
            d    = $urandom;
            busy = 1'($urandom_range(0, 1));
            case (kind)
                0:       base = 32'h3000_0000;
                1:       base = 32'h3001_0000;
                2:       base = 32'h3002_0000;
                3:       base = 32'h3003_0000;
                4:       base = 32'h3004_0000;
                default: base = 32'h3000_0000 | ($urandom_range(5, 15) << 16);
            endcase
            if (kind == 0) off = 16'($urandom_range(0, 5) * 4);
            else           off = 16'($urandom_range(0, 1023) * 4);

            expLat = 1; expRd = '0; expNode = 0; expLeaf = 0; expQuery = 0; expStart = 0; expBest = 0;
            expLeafData = '0; expQueryData = '0;
            if (kind == 0 && we) begin
                if (off == 16'h0) mMode = d[0];
                if (off == 16'h4) mDebug = d[0];
                if (off == 16'h8) mDone = 1'b0;
                if (off == 16'hC && !busy) begin expStart = 1; mDone = 1'b0; end
            end else if (kind == 0) begin
                if (off == 16'h0)  expRd = 32'(mMode);
                if (off == 16'h4)  expRd = 32'(mDebug);
                if (off == 16'h8)  expRd = 32'(mDone);
                if (off == 16'h10) expRd = 32'(busy);
            end else if (kind == 4 && we) begin
                expNode = 1;
            end else if (kind == 2 && we) begin
                if (off[2]) begin expLeaf = 1; expLeafData = {d, mLeafLow}; mLeafLow = '0; end
                else mLeafLow = d;
            end else if (kind == 1 && we) begin
                if (off[2]) begin expQuery = 1; qword = {d, mQueryLow}; expQueryData = qword[54:0]; mQueryLow = '0; end
                else mQueryLow = d;
            end else if (kind == 3 && !we) begin
                expLat = 2; expBest = 1;
                word  = bestMem[off[11:3]];
                expRd = off[2] ? word[63:32] : word[31:0];
            end

            fsm_busy = busy;
            c0 = nodeCnt; c1 = leafCnt; c2 = queryCnt; c3 = startCnt; c4 = bestCnt;
            applyStimulus(we, base | 32'(off), d, 1'b0, rd, lat, sc);
            checkOutput("rnd_lat", 64'(lat), 64'(expLat));
            if (!we) checkOutput("rnd_rdata", 64'(rd), 64'(expRd));
            checkOutput("rnd_node_cnt",  64'(nodeCnt - c0),  64'(expNode));
            checkOutput("rnd_leaf_cnt",  64'(leafCnt - c1),  64'(expLeaf));
            checkOutput("rnd_query_cnt", 64'(queryCnt - c2), 64'(expQuery));
            checkOutput("rnd_start_cnt", 64'(startCnt - c3), 64'(expStart));
            checkOutput("rnd_best_cnt",  64'(bestCnt - c4),  64'(expBest));
            if (expNode) begin
                checkOutput("rnd_node_addr", 64'(lastNodeAddr), 64'(off[7:2]));
                checkOutput("rnd_node_data", 64'(lastNodeData), 64'(d[21:0]));
            end
            if (expLeaf) begin
                checkOutput("rnd_leaf_addr", 64'(lastLeafAddr), 64'(off[11:3]));
                checkOutput("rnd_leaf_data", lastLeafData, expLeafData);
            end
            if (expQuery) begin
                checkOutput("rnd_query_addr", 64'(lastQueryAddr), 64'(off[11:3]));
                checkOutput("rnd_query_data", 64'(lastQueryData), 64'(expQueryData));
            end
            checkOutput("rnd_mode_dbg", 64'({mode_o, debug_o}), 64'({mMode, mDebug}));
            if ($urandom_range(0, 3) == 0) begin
                pulseFsmDone();
                mDone = 1'b1;
            end
        end
        fsm_busy = 1'b0;

        // Reset in the middle of a BEST read
        applyStimulus(1'b1, 32'h3000_0000, 32'h1, 1'b0, rd, lat, sc);
        applyStimulus(1'b1, 32'h3000_0004, 32'h1, 1'b0, rd, lat, sc);
        pulseFsmDone();
        a0 = ackCnt;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3003_0028;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ack_dat", 64'({wbs_ack_o, wbs_dat_o}), 64'(0));
        checkOutput("midrst_strobes", 64'({node_we, leaf_we, query_we, best_re, fsm_start}), 64'(0));
        checkOutput("midrst_addrs",   64'({node_addr, leaf_addr, query_addr, best_addr}), 64'(0));
        checkOutput("midrst_wdata",   64'(leaf_wdata | 64'(query_wdata) | 64'(node_wdata)), 64'(0));
        checkOutput("midrst_mode_dbg", 64'({mode_o, debug_o}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_no_ack", 64'(ackCnt - a0), 64'(0));
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 1'b0, rd, lat, sc);
        checkOutput("midrst_done_clr", 64'(rd), 64'(0));
        applyStimulus(1'b0, 32'h3005_0000, 32'h0, 1'b0, rd, lat, sc);
        checkOutput("unmapped_lat",  64'(lat), 64'(1));
        checkOutput("unmapped_data", 64'(rd), 64'(0));

        checkOutput("strobe_onehot", 64'(overlapCnt), 64'(0));
        checkOutput("dat_idle_zero", 64'(leakCnt), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
